host_cmd_seq: RTL and testbench

Host-side command sequencer that drives the DSO_dig command interface over a byte-level UART. It accepts a 24-bit command, serialises it MSB-first as three bytes on the UART transmitter handshake, then collects the response: one byte for ordinary opcodes, DUMP_LEN bytes for DUMP_CH. It sits directly upstream of DSO_dig's UART command receiver and replaces hand-sequenced byte tasks in benches and host logic.

---
 rtl/dso_cmd_pkg.sv | 43 ++++
 rtl/host_cmd_seq_if.sv | 28 ++
 rtl/host_cmd_seq.sv | 171 +++++++++++++++++
 tb/tb_host_cmd_seq.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dso_cmd_pkg.sv
// Shared command definitions for the DSO_dig command link.
// Holds the byte/command widths, opcode and response constants, the host
// sequencer state enum and the write-type opcode classifier.
// No ports (package).
package dso_cmd_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CMD_W  = 24;

  // Opcodes
  localparam logic [BYTE_W-1:0] DUMP_CH     = 8'h01;
  localparam logic [BYTE_W-1:0] CFG_GAIN    = 8'h02;
  localparam logic [BYTE_W-1:0] CFG_TRG_LVL = 8'h03;
  localparam logic [BYTE_W-1:0] CFG_TRG_POS = 8'h04;
  localparam logic [BYTE_W-1:0] CFG_DEC     = 8'h05;
  localparam logic [BYTE_W-1:0] CFG_TRG_CFG = 8'h06;
  localparam logic [BYTE_W-1:0] TRIG_RD     = 8'h07;
  localparam logic [BYTE_W-1:0] EEP_WRT     = 8'h08;
  localparam logic [BYTE_W-1:0] EEP_RD      = 8'h09;

  // Response bytes
  localparam logic [BYTE_W-1:0] ACK = 8'hA5;
  localparam logic [BYTE_W-1:0] NAK = 8'hEE;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STRB,
    WAIT_TX,
    RESP,
    DONE
  } seq_state_t;

  // Data-returning opcodes are not ack-checked; anything else (including
  // unknown opcodes) must be answered with ACK.
  function automatic logic is_write_op(input logic [BYTE_W-1:0] op);
    case (op)
      DUMP_CH, TRIG_RD, EEP_RD: return 1'b0;
      default:                  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/host_cmd_seq_if.sv
// Byte-level UART handshake between the host command sequencer and the
// UART transmitter/receiver pair.
//   tx_data/trmt   : byte and one-cycle transmit strobe to the transmitter
//   tx_done        : transmitter level, high once the byte has finished
//   rx_data/rx_rdy : received byte and its valid level from the receiver
//   clr_rx_rdy     : one-cycle pulse clearing rx_rdy
// master = sequencer side, slave = UART side.
interface host_cmd_seq_if;
  import dso_cmd_pkg::*;

  logic [BYTE_W-1:0] tx_data;
  logic              trmt;
  logic              tx_done;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_rdy;
  logic              clr_rx_rdy;

  modport master (
    output tx_data, trmt, clr_rx_rdy,
    input  tx_done, rx_data, rx_rdy
  );

  modport slave (
    input  tx_data, trmt, clr_rx_rdy,
    output tx_done, rx_data, rx_rdy
  );

endinterface

// File: rtl/host_cmd_seq.sv
// Host-side command sequencer: sends a 24-bit command MSB-first as three
// UART bytes, then collects one response byte (DUMP_LEN for DUMP_CH),
// flagging NAKs on write-type opcodes and inter-byte timeouts.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   cmd, send_cmd     : command word and capture strobe (honoured in IDLE)
//   busy              : command in progress
//   cmd_sent          : pulse when the third byte has been transmitted
//   resp, resp_vld    : latest response byte and its one-cycle valid
//   resp_last         : with resp_vld on the final response byte
//   nak_err, to_err   : sticky error flags, cleared on the next capture
//   uart              : UART byte handshake (master side)
module host_cmd_seq
  import dso_cmd_pkg::*;
#(
  parameter int unsigned DUMP_LEN = 512,
  parameter int unsigned TO_CYC   = 1_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CMD_W-1:0]   cmd,
  input  logic               send_cmd,
  output logic               busy,
  output logic               cmd_sent,
  output logic [BYTE_W-1:0]  resp,
  output logic               resp_vld,
  output logic               resp_last,
  output logic               nak_err,
  output logic               to_err,
  host_cmd_seq_if.master     uart
);

  localparam int unsigned RX_W = $clog2(DUMP_LEN + 1);
  localparam int unsigned TO_W = $clog2(TO_CYC + 1);

  seq_state_t        state;
  logic [CMD_W-1:0]  cmd_q;
  logic [1:0]        idx;
  logic [RX_W-1:0]   rx_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              tx_done_q;
  logic              rx_armed;

  logic              tx_rise;
  logic              rx_take;
  logic [RX_W-1:0]   rx_exp;
  logic [TO_W-1:0]   to_inc;
  logic              to_hit;
  logic [BYTE_W-1:0] cur_byte;

  assign tx_rise = uart.tx_done & ~tx_done_q;
  // A byte is new only if rx_rdy has been seen low since the last accept.
  assign rx_take = uart.rx_rdy & rx_armed;
  assign rx_exp  = (cmd_q[23:16] == DUMP_CH) ? RX_W'(DUMP_LEN) : RX_W'(1);
  // Saturating timeout increment and its terminal compare.
  assign to_inc  = (to_cnt == TO_W'(TO_CYC)) ? to_cnt : to_cnt + TO_W'(1);
  assign to_hit  = (to_inc == TO_W'(TO_CYC));

  // MSB-first byte select
  always_comb begin
    cur_byte = cmd_q[7:0];
    case (idx)
      2'd0:    cur_byte = cmd_q[23:16];
      2'd1:    cur_byte = cmd_q[15:8];
      default: cur_byte = cmd_q[7:0];
    endcase
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cmd_q           <= '0;
      idx             <= '0;
      rx_cnt          <= '0;
      to_cnt          <= '0;
      tx_done_q       <= 1'b0;
      rx_armed        <= 1'b0;
      busy            <= 1'b0;
      cmd_sent        <= 1'b0;
      resp            <= '0;
      resp_vld        <= 1'b0;
      resp_last       <= 1'b0;
      nak_err         <= 1'b0;
      to_err          <= 1'b0;
      uart.tx_data    <= '0;
      uart.trmt       <= 1'b0;
      uart.clr_rx_rdy <= 1'b0;
    end else begin
      uart.trmt       <= 1'b0;
      uart.clr_rx_rdy <= 1'b0;
      cmd_sent        <= 1'b0;
      resp_vld        <= 1'b0;
      resp_last       <= 1'b0;
      tx_done_q       <= uart.tx_done;
      if (!uart.rx_rdy) rx_armed <= 1'b1;

      case (state)
        IDLE: begin
          if (send_cmd) begin
            cmd_q   <= cmd;
            busy    <= 1'b1;
            nak_err <= 1'b0;
            to_err  <= 1'b0;
            idx     <= '0;
            to_cnt  <= '0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          uart.tx_data <= cur_byte;
          state        <= STRB;
        end
        STRB: begin
          uart.trmt <= 1'b1;
          to_cnt    <= '0;
          state     <= WAIT_TX;
        end
        WAIT_TX: begin
          if (tx_rise) begin
            if (idx == 2'd2) begin
              cmd_sent <= 1'b1;
              rx_cnt   <= '0;
              to_cnt   <= '0;
              state    <= RESP;
            end else begin
              idx   <= idx + 2'd1;
              state <= LOAD;
            end
          end else if (to_hit) begin
            to_cnt <= to_inc;
            to_err <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            to_cnt <= to_inc;
          end
        end
        RESP: begin
          if (rx_take) begin
            resp            <= uart.rx_data;
            resp_vld        <= 1'b1;
            uart.clr_rx_rdy <= 1'b1;
            rx_armed        <= 1'b0;
            rx_cnt          <= rx_cnt + RX_W'(1);
            to_cnt          <= '0;
            if (is_write_op(cmd_q[23:16]) && (uart.rx_data != ACK))
              nak_err <= 1'b1;
            if ((rx_cnt + RX_W'(1)) == rx_exp) begin
              resp_last <= 1'b1;
              state     <= DONE;
            end
          end else if (to_hit) begin
            to_cnt <= to_inc;
            to_err <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            to_cnt <= to_inc;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_host_cmd_seq.sv
// Directed bench for host_cmd_seq with a transmitter model (fixed tx_done
// latency, optional hang on a chosen byte) and a receiver driven byte by
// byte from the main sequence.
module tb_host_cmd_seq;
  import dso_cmd_pkg::*;

  localparam int unsigned DLEN   = 8;
  localparam int unsigned TOC    = 100;
  localparam int unsigned TX_LAT = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] cmd;
  logic        send_cmd;
  logic        busy, cmd_sent, resp_vld, resp_last, nak_err, to_err;
  logic [7:0]  resp;

  host_cmd_seq_if u_if ();

  host_cmd_seq #(.DUMP_LEN(DLEN), .TO_CYC(TOC)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd),
    .send_cmd  (send_cmd),
    .busy      (busy),
    .cmd_sent  (cmd_sent),
    .resp      (resp),
    .resp_vld  (resp_vld),
    .resp_last (resp_last),
    .nak_err   (nak_err),
    .to_err    (to_err),
    .uart      (u_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge
  int         cyc = 0;
  int         n_trmt = 0, n_sent = 0, n_vld = 0, n_clr = 0, n_last = 0, lone_last = 0;
  int         t_trmt = 0, t_to = 0;
  logic       to_q = 1'b0;
  logic [7:0] last_at_last = 8'h00;
  logic [7:0] tx_log[$];
  logic [7:0] resp_log[$];

  always @(negedge clk) begin
    cyc++;
    if (u_if.trmt === 1'b1) begin
      tx_log.push_back(u_if.tx_data);
      n_trmt++;
      t_trmt = cyc;
    end
    if (cmd_sent === 1'b1) n_sent++;
    if (u_if.clr_rx_rdy === 1'b1) n_clr++;
    if (resp_vld === 1'b1) begin
      resp_log.push_back(resp);
      n_vld++;
    end
    if (resp_last === 1'b1) begin
      n_last++;
      last_at_last = resp;
      if (resp_vld !== 1'b1) lone_last++;
    end
    if (to_err === 1'b1 && to_q !== 1'b1) t_to = cyc;
    to_q = to_err;
  end

  // Transmitter model: tx_done drops on trmt, rises TX_LAT cycles later
  // unless this is the byte chosen to hang.
  int hang_on = -1;
  int tx_seen = 0;
  initial begin
    u_if.tx_done = 1'b1;
    forever begin
      @(negedge clk);
      if (u_if.trmt === 1'b1) begin
        tx_seen++;
        u_if.tx_done = 1'b0;
        repeat (TX_LAT) @(negedge clk);
        if (tx_seen != hang_on) u_if.tx_done = 1'b1;
      end
    end
  end

  int b_trmt, b_sent, b_vld, b_clr, b_last, b_tx, b_rs;

  task automatic snap();
    b_trmt = n_trmt; b_sent = n_sent; b_vld = n_vld; b_clr = n_clr;
    b_last = n_last; b_tx = tx_log.size(); b_rs = resp_log.size();
  endtask

  task automatic issue(input logic [23:0] c);
    @(negedge clk);
    cmd = c;
    send_cmd = 1'b1;
    @(negedge clk);
    send_cmd = 1'b0;
  endtask

  task automatic wait_sent(input string tag);
    int k = 0;
    while (cmd_sent !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(cmd_sent), 32'(1));
  endtask

  task automatic rx_byte(input string tag, input logic [7:0] b, input int hold);
    int k = 0;
    @(negedge clk);
    u_if.rx_data = b;
    u_if.rx_rdy  = 1'b1;
    do begin
      @(negedge clk);
      k++;
    end while (u_if.clr_rx_rdy !== 1'b1 && k < 300);
    chk(tag, 32'(u_if.clr_rx_rdy), 32'(1));
    repeat (hold) @(negedge clk);
    u_if.rx_rdy = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(busy), 32'(0));
  endtask

  initial begin
    int k;
    rst = 1'b1;
    send_cmd = 1'b0;
    cmd = '0;
    u_if.rx_rdy = 1'b0;
    u_if.rx_data = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_busy",    32'(busy), 32'(0));
    chk("rst_tx_data", 32'(u_if.tx_data), 32'(0));
    chk("rst_pulses",  32'({u_if.trmt, cmd_sent, resp_vld, resp_last, u_if.clr_rx_rdy}), 32'(0));
    chk("rst_errs",    32'({nak_err, to_err}), 32'(0));
    chk("rst_resp",    32'(resp), 32'(0));
    rst = 1'b0;

    // EEP_WRT acked
    snap();
    issue(24'h08_2ABB);
    chk("t1_busy_up", 32'(busy), 32'(1));
    wait_sent("t1_sent");
    rx_byte("t1_clr", ACK, 0);
    wait_idle("t1_idle");
    chk("t1_n_trmt", 32'(n_trmt - b_trmt), 32'(3));
    chk("t1_tx0", 32'(tx_log[b_tx]),     32'(8'h08));
    chk("t1_tx1", 32'(tx_log[b_tx + 1]), 32'(8'h2A));
    chk("t1_tx2", 32'(tx_log[b_tx + 2]), 32'(8'hBB));
    chk("t1_n_sent", 32'(n_sent - b_sent), 32'(1));
    chk("t1_n_vld",  32'(n_vld - b_vld),   32'(1));
    chk("t1_n_last", 32'(n_last - b_last), 32'(1));
    chk("t1_last_b", 32'(last_at_last),    32'(8'hA5));
    chk("t1_nak",    32'(nak_err),         32'(0));

    // CFG_GAIN answered NAK
    snap();
    issue(24'h02_1CFF);
    wait_sent("t2_sent");
    rx_byte("t2_clr", NAK, 0);
    wait_idle("t2_idle");
    chk("t2_nak",    32'(nak_err), 32'(1));
    chk("t2_n_last", 32'(n_last - b_last), 32'(1));
    chk("t2_resp",   32'(resp), 32'(8'hEE));

    // EEP_RD returning data; send_cmd while busy must be ignored
    snap();
    issue(24'h09_2AFF);
    chk("t3_nak_clr", 32'(nak_err), 32'(0));
    repeat (3) @(negedge clk);
    cmd = 24'h03_0405;
    send_cmd = 1'b1;
    @(negedge clk);
    send_cmd = 1'b0;
    wait_sent("t3_sent");
    rx_byte("t3_clr", 8'hBB, 0);
    wait_idle("t3_idle");
    chk("t3_n_trmt", 32'(n_trmt - b_trmt), 32'(3));
    chk("t3_tx0", 32'(tx_log[b_tx]),     32'(8'h09));
    chk("t3_tx1", 32'(tx_log[b_tx + 1]), 32'(8'h2A));
    chk("t3_tx2", 32'(tx_log[b_tx + 2]), 32'(8'hFF));
    chk("t3_resp", 32'(resp), 32'(8'hBB));
    chk("t3_nak",  32'(nak_err), 32'(0));

    // TRIG_RD returning data
    issue(24'h07_0000);
    wait_sent("t4_sent");
    rx_byte("t4_clr", 8'h38, 0);
    wait_idle("t4_idle");
    chk("t4_resp", 32'(resp), 32'(8'h38));
    chk("t4_errs", 32'({nak_err, to_err}), 32'(0));

    // DUMP_CH: first byte's rx_rdy held past clr must count once
    snap();
    issue(24'h01_00FF);
    wait_sent("t5_sent");
    rx_byte("t5_clr0", 8'h00, 2);
    for (int i = 1; i < 8; i++) rx_byte("t5_clr", 8'(i), 0);
    wait_idle("t5_idle");
    chk("t5_n_vld",  32'(n_vld - b_vld),   32'(8));
    chk("t5_n_clr",  32'(n_clr - b_clr),   32'(8));
    chk("t5_n_last", 32'(n_last - b_last), 32'(1));
    chk("t5_last_b", 32'(last_at_last),    32'(8'h07));
    for (int i = 0; i < 8; i++) chk("t5_resp_seq", 32'(resp_log[b_rs + i]), 32'(i));
    chk("t5_nak", 32'(nak_err), 32'(0));

    // Timeout: second byte never completes
    hang_on = n_trmt + 2;
    snap();
    issue(24'h08_1122);
    k = 0;
    while (to_err !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk("t6_to_err",  32'(to_err), 32'(1));
    chk("t6_to_cyc",  32'(t_to - t_trmt), 32'(TOC));
    chk("t6_busy",    32'(busy), 32'(0));
    chk("t6_n_trmt",  32'(n_trmt - b_trmt), 32'(2));
    chk("t6_n_sent",  32'(n_sent - b_sent), 32'(0));
    chk("t6_n_last",  32'(n_last - b_last), 32'(0));
    hang_on = -1;

    // Recovery after timeout
    snap();
    issue(24'h08_2ABB);
    chk("t7_to_clr", 32'(to_err), 32'(0));
    wait_sent("t7_sent");
    rx_byte("t7_clr", ACK, 0);
    wait_idle("t7_idle");
    chk("t7_n_last", 32'(n_last - b_last), 32'(1));
    chk("t7_errs",   32'({nak_err, to_err}), 32'(0));

    // Reset mid-DUMP after three bytes; send_cmd alongside rst is ignored
    issue(24'h01_00FF);
    wait_sent("t8_sent");
    for (int i = 0; i < 3; i++) rx_byte("t8_clr", 8'(i), 0);
    chk("t8_busy_pre", 32'(busy), 32'(1));
    @(negedge clk);
    rst = 1'b1;
    send_cmd = 1'b1;
    cmd = 24'h08_1122;
    @(negedge clk);
    chk("t8_busy",    32'(busy), 32'(0));
    chk("t8_resp",    32'(resp), 32'(0));
    chk("t8_tx_data", 32'(u_if.tx_data), 32'(0));
    chk("t8_pulses",  32'({u_if.trmt, cmd_sent, resp_vld, resp_last, u_if.clr_rx_rdy}), 32'(0));
    chk("t8_errs",    32'({nak_err, to_err}), 32'(0));
    rst = 1'b0;
    send_cmd = 1'b0;
    snap();
    repeat (10) @(negedge clk);
    chk("t8_idle",   32'(busy), 32'(0));
    chk("t8_n_trmt", 32'(n_trmt - b_trmt), 32'(0));

    // Normal command after reset
    snap();
    issue(24'h07_0000);
    wait_sent("t9_sent");
    rx_byte("t9_clr", 8'h38, 0);
    wait_idle("t9_idle");
    chk("t9_n_last", 32'(n_last - b_last), 32'(1));
    chk("t9_resp",   32'(resp), 32'(8'h38));

    chk("last_with_vld", 32'(lone_last), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
